jk_driver: RTL

Sequential controller that drives the J/K inputs of a bank of N JK flip-flops (one per irrigation sector valve) and confirms each write from the flip-flop outputs. It takes a request (target state and mask) through a valid/ready handshake and issues the J/K excitation for one cycle. It then reads the flip-flop outputs back, retries on mismatch, and reports completion with an error flag. It sits between the irrigation control FSM and the valve flip-flop bank.

---
 rtl/rega_pkg.sv | 14 +
 rtl/jk_excite.sv | 26 ++
 rtl/jk_driver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rega_pkg.sv
// Shared types and default sizing for the valve flip-flop driver.
package rega_pkg;

    localparam int DEFAULT_N         = 4;
    localparam int DEFAULT_MAX_RETRY = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

endpackage

// File: rtl/jk_excite.sv
// J/K excitation for a bank of JK flip-flops: set/clear toward an expected
// value, or a plain toggle of the masked bits on the first attempt.
module jk_excite
    import rega_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] expected,
    input  logic [N-1:0] mask,
    input  logic         toggle_first,
    output logic [N-1:0] j,
    output logic [N-1:0] k
);

    // Set/clear terms are mutually exclusive per bit, so J&K only occurs on toggle.
    always_comb begin
        j = mask & expected & ~q;
        k = mask & ~expected & q;
        if (toggle_first) begin
            j = mask;
            k = mask;
        end
    end

endmodule

// File: rtl/jk_driver.sv
// Drives J/K of a valve flip-flop bank, reads back q_fb and retries on mismatch.
// Optional toggle requests are compiled in with `define JK_TOGGLE_EN.
module jk_driver
    import rega_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int MAX_RETRY = DEFAULT_MAX_RETRY
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_target,
    input  logic [N-1:0] req_mask,
    input  logic         req_toggle,
    output logic [N-1:0] J,
    output logic [N-1:0] K,
    input  logic [N-1:0] q_fb,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_e        state_q, state_d;
    logic [N-1:0]  j_q, j_d;
    logic [N-1:0]  k_q, k_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [N-1:0]  expected_q, expected_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          err_q, err_d;

    logic          accept_toggle;
    logic [N-1:0]  accept_expected;
    logic [N-1:0]  mismatch;
    logic [N-1:0]  ex_expected, ex_mask, ex_j, ex_k;
    logic          ex_toggle;

`ifdef JK_TOGGLE_EN
    assign accept_toggle = req_toggle;
`else
    logic unused_req_toggle;
    assign unused_req_toggle = req_toggle;
    assign accept_toggle     = 1'b0;
`endif

    // A toggle targets the complement of the masked bits as seen at accept.
    assign accept_expected = accept_toggle ? (q_fb ^ req_mask) : req_target;
    assign mismatch        = (q_fb ^ expected_q) & mask_q;

    // One excitation block serves both the initial drive and the retries.
    always_comb begin
        ex_expected = accept_expected;
        ex_mask     = req_mask;
        ex_toggle   = accept_toggle;
        if (state_q == CHECK) begin
            ex_expected = expected_q;
            ex_mask     = mask_q;
            ex_toggle   = 1'b0;
        end
    end

    jk_excite #(.N(N)) u_excite (
        .q            (q_fb),
        .expected     (ex_expected),
        .mask         (ex_mask),
        .toggle_first (ex_toggle),
        .j            (ex_j),
        .k            (ex_k)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        j_d        = '0;
        k_d        = '0;
        mask_d     = mask_q;
        expected_d = expected_q;
        retry_d    = retry_q;
        err_d      = err_q;
        done       = 1'b0;
        err        = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mask_d     = req_mask;
                    expected_d = accept_expected;
                    retry_d    = '0;
                    err_d      = 1'b0;
                    j_d        = ex_j;
                    k_d        = ex_k;
                    state_d    = DRIVE;
                end
            end
            DRIVE:  state_d = SETTLE;
            SETTLE: state_d = CHECK;
            CHECK: begin
                if (mismatch == '0) begin
                    done    = 1'b1;
                    err     = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + RW'(1);
                    j_d     = ex_j;
                    k_d     = ex_k;
                    state_d = DRIVE;
                end else begin
                    done    = 1'b1;
                    err     = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            j_q        <= '0;
            k_q        <= '0;
            mask_q     <= '0;
            expected_q <= '0;
            retry_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            mask_q     <= mask_d;
            expected_q <= expected_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

endmodule
